divider: RTL

DIVIDER -- requirements
Module: divider

---
 rtl/divider.sv | 95 +++++++++
 1 files changed

// File: rtl/divider.sv
// divider: 32-bit signed/unsigned radix-2 restoring divider, one quotient bit per cycle.
// result = {remainder, quotient}; ready pulses for one cycle when result is updated.
module divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        annul,
    output logic [63:0] result,
    output logic        ready,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
    state_t      state;
    logic [5:0]  cnt;
    logic [64:0] pr;
    logic [31:0] dvs;
    logic        q_neg;
    logic        r_neg;
    logic [64:0] sh;
    logic [64:0] nxt;
    logic [32:0] diff;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    // pr holds {partial remainder, dividend bits shifting into quotient bits}
    always_comb begin
        sh    = pr << 1;
        diff  = sh[64:32] - {1'b0, dvs};
        nxt   = diff[32] ? sh : {diff, sh[31:1], 1'b1};
        q_fix = q_neg ? -nxt[31:0] : nxt[31:0];
        r_fix = r_neg ? -nxt[63:32] : nxt[63:32];
        a_mag = (signed_div && a[31]) ? -a : a;
        b_mag = (signed_div && b[31]) ? -b : b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 6'd0;
            pr     <= 65'd0;
            dvs    <= 32'd0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            result <= 64'd0;
            ready  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready <= 1'b0;
                    if (start && !annul) begin
                        if (b == 32'd0) begin
                            state  <= DONE;
                            result <= 64'd0;
                            ready  <= 1'b1;
                        end else begin
                            state <= ITER;
                            busy  <= 1'b1;
                            cnt   <= 6'd0;
                            pr    <= {33'd0, a_mag};
                            dvs   <= b_mag;
                            q_neg <= signed_div && (a[31] ^ b[31]);
                            r_neg <= signed_div && a[31];
                        end
                    end
                end
                ITER: begin
                    if (annul) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        pr  <= nxt;
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'd31) begin
                            state  <= DONE;
                            busy   <= 1'b0;
                            ready  <= 1'b1;
                            result <= {r_fix, q_fix};
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ready <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
